// File: rtl/jtyiear_pkg.sv
// jtyiear_pkg
//   Constants shared by the ROM download path of the Yie Ar Kung-Fu core.
//   - Region bases of the ioctl byte stream. CPU, sound and gfx go to SDRAM.
//     The palette PROM sits above the SDRAM regions.
//   - Palette PROM size.
//   - State encoding of the SDRAM write buffer.
package jtyiear_pkg;

    localparam int DL_AW = 22;

    // ioctl byte-stream layout. The SDRAM mapper uses these offsets.
    localparam logic [DL_AW-1:0] CPU_START  = 22'h0_0000;
    localparam logic [DL_AW-1:0] SND_START  = 22'h1_0000;
    localparam logic [DL_AW-1:0] GFX_START  = 22'h1_2000;
    localparam logic [DL_AW-1:0] PROM_START = 22'h2_8000;

    localparam int PROM_LEN = 32;
    localparam int PROM_AW  = 5;

    // The one-entry SDRAM buffer is either empty (IDLE) or holding a
    // request that has not yet been acknowledged (WAIT).
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sdr_state_t;

endpackage

// File: rtl/jtyiear_prom_we.sv
// jtyiear_prom_we
//   Routes the framework ROM-download byte stream to the game memories.
//   - Bytes below PROM_START go to SDRAM through a one-entry buffer with a
//     req/ack handshake.
//   - Bytes in [PROM_START, PROM_START+PROM_LEN) are written to the palette
//     PROM port one cycle after the strobe. This path never stalls.
//   - Bytes above the PROM window are discarded, and ovf is flagged.
//
// Ports
//   clk, rst_n          system clock and asynchronous active-low reset
//   downloading         framework download window
//   ioctl_addr/dout/wr  incoming byte stream (wr is a one-cycle strobe)
//   sdr_addr/data/req   SDRAM write request, held until sdr_ack
//   sdr_ack             one-cycle acknowledge
//   prog_addr/data/en   palette PROM write port (en is one cycle)
//   dwnld_busy          downloading or an SDRAM write still pending
//   ovf                 sticky error: a dropped strobe or an out-of-range PROM byte
module jtyiear_prom_we #(
    parameter int              AW         = 22,
    parameter logic [AW-1:0]   PROM_START = AW'(jtyiear_pkg::PROM_START),
    parameter int              PROM_LEN   = jtyiear_pkg::PROM_LEN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ioctl_wr,
    output logic [AW-1:0] sdr_addr,
    output logic [7:0]    sdr_data,
    output logic          sdr_req,
    input  logic          sdr_ack,
    output logic [4:0]    prog_addr,
    output logic [7:0]    prog_data,
    output logic          prog_en,
    output logic          dwnld_busy,
    output logic          ovf
);
    import jtyiear_pkg::*;

    localparam logic [AW-1:0] PROM_LEN_AW = AW'(PROM_LEN);

    logic [AW-1:0] prom_off;
    logic          in_sdr, in_prom;
    logic          sdr_wr, accept, drop, oor;
    logic          dl_q;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_data;
    sdr_state_t    state, state_nx;

    // Decode. The offset is taken at full width so that an address far above
    // the window cannot alias into the 5-bit PROM range.
    assign prom_off = ioctl_addr - PROM_START;
    assign in_sdr   = ioctl_addr < PROM_START;
    assign in_prom  = !in_sdr && (prom_off < PROM_LEN_AW);
    assign sdr_wr   = ioctl_wr && in_sdr;
    assign oor      = ioctl_wr && !in_sdr && !in_prom;

    // A new SDRAM byte fits if the buffer is empty, or if it is being
    // emptied this very cycle by sdr_ack.
    assign accept = sdr_wr && ((state == IDLE) || sdr_ack);
    assign drop   = sdr_wr && (state == WAIT) && !sdr_ack;

    // ---------------- SDRAM buffer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sdr_wr) state_nx = WAIT;
            WAIT:    if (sdr_ack && !sdr_wr) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sdr_req  = (state == WAIT);
        sdr_addr = req_addr;
        sdr_data = req_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr <= '0;
            req_data <= '0;
        end else if (accept) begin
            req_addr <= ioctl_addr;
            req_data <= ioctl_dout;
        end
    end

    // ---------------- PROM write port ----------------
    // The address and data hold their last values between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_en   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            prog_en <= ioctl_wr && in_prom;
            if (ioctl_wr && in_prom) begin
                prog_addr <= prom_off[4:0];
                prog_data <= ioctl_dout;
            end
        end
    end

    // ---------------- Status ----------------
    // If a new error arrives on the same cycle as the rising edge of
    // downloading, the error is kept, so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            dwnld_busy <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            dl_q       <= downloading;
            dwnld_busy <= downloading || (state != IDLE);
            if (drop || oor)             ovf <= 1'b1;
            else if (downloading && !dl_q) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtyiear_prom_we.sv
module tb_jtyiear_prom_we;

    localparam int          AW    = 22;
    localparam logic [21:0] PBASE = 22'h2_8000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          downloading;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic [AW-1:0] sdr_addr;
    logic [7:0]    sdr_data;
    logic          sdr_req;
    logic          sdr_ack;
    logic [4:0]    prog_addr;
    logic [7:0]    prog_data;
    logic          prog_en;
    logic          dwnld_busy;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    jtyiear_prom_we dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .dwnld_busy(dwnld_busy), .ovf(ovf)
    );

    always #10 clk = ~clk;

    // Reference model: a pending-write slot plus status flags, advanced once
    // per clock from the routing rules.
    logic          m_req, m_busy, m_ovf, m_pen, m_dl;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data, m_pdata;
    logic [4:0]    m_paddr;

    function automatic void model_reset();
        m_req = 0; m_busy = 0; m_ovf = 0; m_pen = 0; m_dl = 0;
        m_addr = 0; m_data = 0; m_pdata = 0; m_paddr = 0;
    endfunction

    function automatic void model_step(logic dl, logic wr, logic [AW-1:0] a,
                                       logic [7:0] d, logic ack);
        logic loaded;
        int   off;
        loaded = 0;
        m_busy = dl | m_req;
        if (dl && !m_dl) m_ovf = 0;
        m_pen = 0;
        if (wr) begin
            if (a < PBASE) begin
                if (!m_req || ack) begin
                    m_req = 1; m_addr = a; m_data = d; loaded = 1;
                end else m_ovf = 1;
            end else begin
                off = int'(a) - int'(PBASE);
                if (off < 32) begin
                    m_pen = 1; m_paddr = off[4:0]; m_pdata = d;
                end else m_ovf = 1;
            end
        end
        if (!loaded && ack) m_req = 0;
        m_dl = dl;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ioctl_wr = 0; sdr_ack = 0; ioctl_addr = 0; ioctl_dout = 0;
    endtask

    task automatic do_reset();
        #3 rst_n = 0;
        idle_in();
        #20 rst_n = 1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0; downloading = 0; idle_in();
        #25;
        checks++;
        if ({sdr_req, prog_en, dwnld_busy, ovf} !== 4'b0 || sdr_addr !== '0 ||
            sdr_data !== 8'h0 || prog_addr !== 5'h0 || prog_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs req=%b pen=%b busy=%b ovf=%b expected all zero",
                     sdr_req, prog_en, dwnld_busy, ovf);
        end
        rst_n = 1;
        tick(); tick();
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++; $display("FAIL idle_busy got=%b exp=0", dwnld_busy);
        end
        downloading = 1;
        #1;
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++; $display("FAIL busy_latency got=%b exp=0 before edge", dwnld_busy);
        end
        tick();
        checks++;
        if (dwnld_busy !== 1'b1) begin
            errors++; $display("FAIL busy_rise got=%b exp=1", dwnld_busy);
        end
    endtask

    task automatic test_prom();
        ioctl_addr = 22'h2_8005; ioctl_dout = 8'hA7; ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        checks++;
        if (prog_en !== 1'b1 || prog_addr !== 5'd5 || prog_data !== 8'hA7 || sdr_req !== 1'b0) begin
            errors++;
            $display("FAIL prom_write en=%b addr=%h data=%h req=%b exp 1/05/a7/0",
                     prog_en, prog_addr, prog_data, sdr_req);
        end
        tick();
        checks++;
        if (prog_en !== 1'b0) begin
            errors++; $display("FAIL prom_one_shot en=%b exp=0", prog_en);
        end
    endtask

    task automatic test_sdram();
        ioctl_addr = 22'h0_0100; ioctl_dout = 8'h3C; ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sdr_req !== 1'b1 || sdr_addr !== 22'h100 || sdr_data !== 8'h3C) begin
                errors++;
                $display("FAIL sdr_hold cyc=%0d req=%b addr=%h data=%h exp 1/100/3c",
                         i, sdr_req, sdr_addr, sdr_data);
            end
            if (i == 3) sdr_ack = 1;
            tick();
        end
        sdr_ack = 0;
        checks++;
        if (sdr_req !== 1'b0) begin
            errors++; $display("FAIL sdr_release req=%b exp=0", sdr_req);
        end
    endtask

    task automatic test_back_to_back();
        ioctl_addr = 22'h0_0100; ioctl_dout = 8'h3C; ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        tick();
        sdr_ack = 1; ioctl_wr = 1; ioctl_addr = 22'h0_0101; ioctl_dout = 8'h55;
        tick();
        sdr_ack = 0; ioctl_wr = 0;
        checks++;
        if (sdr_req !== 1'b1 || sdr_addr !== 22'h101 || sdr_data !== 8'h55) begin
            errors++;
            $display("FAIL b2b_switch req=%b addr=%h data=%h exp 1/101/55", sdr_req, sdr_addr, sdr_data);
        end
        sdr_ack = 1;
        tick();
        sdr_ack = 0;
        checks++;
        if (sdr_req !== 1'b0) begin
            errors++; $display("FAIL b2b_release req=%b exp=0", sdr_req);
        end
    endtask

    task automatic test_overflow();
        ioctl_addr = PBASE + 22'd32; ioctl_dout = 8'hEE; ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        checks++;
        if (ovf !== 1'b1 || prog_en !== 1'b0) begin
            errors++; $display("FAIL ovf_prom_len ovf=%b pen=%b exp 1/0", ovf, prog_en);
        end
        ioctl_addr = 22'h0_0200; ioctl_dout = 8'h11; ioctl_wr = 1;
        tick();
        ioctl_addr = 22'h0_0300; ioctl_dout = 8'h22;
        tick();
        ioctl_wr = 0;
        checks++;
        if (sdr_req !== 1'b1 || sdr_addr !== 22'h200 || sdr_data !== 8'h11 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop req=%b addr=%h data=%h ovf=%b exp 1/200/11/1",
                     sdr_req, sdr_addr, sdr_data, ovf);
        end
        sdr_ack = 1; tick(); sdr_ack = 0;
        downloading = 0; tick(); tick();
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky ovf=%b exp=1", ovf);
        end
        downloading = 1; tick();
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear ovf=%b exp=0", ovf);
        end
    endtask

    task automatic test_busy_tail();
        ioctl_addr = 22'h0_0400; ioctl_dout = 8'h99; ioctl_wr = 1;
        tick();
        ioctl_wr = 0; downloading = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dwnld_busy !== 1'b1) begin
                errors++; $display("FAIL busy_tail cyc=%0d busy=%b exp=1", i, dwnld_busy);
            end
        end
        sdr_ack = 1; tick(); sdr_ack = 0;
        checks++;
        if (dwnld_busy !== 1'b1 || sdr_req !== 1'b0) begin
            errors++; $display("FAIL busy_ack busy=%b req=%b exp 1/0", dwnld_busy, sdr_req);
        end
        tick();
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++; $display("FAIL busy_end busy=%b exp=0", dwnld_busy);
        end
    endtask

    task automatic test_async_reset();
        downloading = 1;
        ioctl_addr = 22'h0_0500; ioctl_dout = 8'h5A; ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        #4 rst_n = 0;
        #1;
        checks++;
        if (sdr_req !== 1'b0 || dwnld_busy !== 1'b0 || sdr_addr !== '0) begin
            errors++;
            $display("FAIL async_reset req=%b busy=%b addr=%h exp 0/0/0", sdr_req, dwnld_busy, sdr_addr);
        end
        #5 rst_n = 1;
        downloading = 0;
        model_reset();
        tick();
        checks++;
        if (sdr_req !== 1'b0) begin
            errors++; $display("FAIL no_replay req=%b exp=0", sdr_req);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic          w, k;
        model_reset();
        do_reset();
        model_step(downloading, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) downloading = !downloading;
            w = ($urandom_range(0, 9) < 4);
            k = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 5))
                0, 1, 2: a = AW'($urandom_range(0, 32'h27FFF));
                3, 4:    a = PBASE + AW'($urandom_range(0, 31));
                default: a = ($urandom_range(0, 1) == 1) ? PBASE + 22'd32
                                                         : PBASE + 22'd32 + AW'($urandom_range(0, 32'h3D7FDF));
            endcase
            if ($urandom_range(0, 7) == 0) a = PBASE - 22'd1;
            d = 8'($urandom);
            ioctl_addr = a; ioctl_dout = d; ioctl_wr = w; sdr_ack = k;
            model_step(downloading, w, a, d, k);
            tick();
            checks++;
            if (sdr_req !== m_req || dwnld_busy !== m_busy || ovf !== m_ovf || prog_en !== m_pen) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d req/busy/ovf/pen=%b%b%b%b exp %b%b%b%b",
                         n, sdr_req, dwnld_busy, ovf, prog_en, m_req, m_busy, m_ovf, m_pen);
            end
            if (m_req) begin
                checks++;
                if (sdr_addr !== m_addr || sdr_data !== m_data) begin
                    errors++;
                    $display("FAIL rnd_sdr n=%0d addr=%h data=%h exp %h/%h", n, sdr_addr, sdr_data, m_addr, m_data);
                end
            end
            if (m_pen) begin
                checks++;
                if (prog_addr !== m_paddr || prog_data !== m_pdata) begin
                    errors++;
                    $display("FAIL rnd_prom n=%0d addr=%h data=%h exp %h/%h", n, prog_addr, prog_data, m_paddr, m_pdata);
                end
            end
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_prom();
        test_sdram();
        test_back_to_back();
        test_overflow();
        test_busy_tail();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
